pwm_capture: RTL



---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_capture_ch.sv | 119 +++++++++++
 rtl/pwm_capture.sv | 76 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture register slice.
// Holds channel count, register stride and offsets, CTRL bit positions,
// the capture FSM state type and a helper for channel base addresses.
package pwm_pkg;

    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned CH_STRIDE = 12;
    localparam int unsigned ADRS_W    = 7;

    localparam logic [ADRS_W-1:0] OFS_CTRL   = 7'd0;
    localparam logic [ADRS_W-1:0] OFS_PERIOD = 7'd4;
    localparam logic [ADRS_W-1:0] OFS_HIGH   = 7'd8;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_VALID = 1;
    localparam int unsigned CTRL_OVF   = 2;
    localparam int unsigned CTRL_IE    = 3;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMING  = 2'd1,
        CAP_MEASURE = 2'd2
    } cap_state_t;

    function automatic logic [ADRS_W-1:0] ch_base(input int unsigned ch,
                                                  input int unsigned stride);
        return ADRS_W'(ch * stride);
    endfunction

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: input synchronizer, edge detector, capture FSM,
// period/high counter and the channel's CTRL/PERIOD/HIGH registers.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   pwmi         - asynchronous PWM input
//   ctrl_wr      - write strobe for this channel's CTRL register
//   ctrl_wdata   - CTRL write data (EN/IE loaded, VALID/OVF are W1C)
//   ctrl         - {IE, OVF, VALID, EN}
//   period, high - last captured period and high time in clk cycles
//   irq_req      - VALID & IE
module pwm_capture_ch
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwmi,
    input  logic             ctrl_wr,
    input  logic [3:0]       ctrl_wdata,
    output logic [3:0]       ctrl,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic             irq_req
);

    logic             sync1, sync2, sync_d;
    logic             rise, fall;
    logic             en, ie, valid, ovf;
    logic             arm, cap, sat;
    logic [CNT_W-1:0] cnt, hi_tmp;
    cap_state_t       state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= pwmi;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync_d;
    assign fall = ~sync2 & sync_d;

    always_ff @(posedge clk) begin
        if (rst) state <= CAP_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        cap       = 1'b0;
        sat       = 1'b0;
        case (state)
            CAP_IDLE: begin
                if (en) state_nxt = CAP_ARMING;
            end
            CAP_ARMING: begin
                if (!en) begin
                    state_nxt = CAP_IDLE;
                end else if (rise) begin
                    state_nxt = CAP_MEASURE;
                    arm       = 1'b1;
                end
            end
            CAP_MEASURE: begin
                if (!en)           state_nxt = CAP_IDLE;
                else if (rise)     cap = 1'b1;
                else if (cnt == '1) sat = 1'b1;
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

    // The counter also advances on the fall cycle so the next rise sees the
    // full period length; a fall only snapshots the running count.
    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= 1'b0;
            ie     <= 1'b0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
            hi_tmp <= '0;
            period <= '0;
            high   <= '0;
        end else begin
            if (ctrl_wr) begin
                en <= ctrl_wdata[CTRL_EN];
                ie <= ctrl_wdata[CTRL_IE];
            end
            // set beats a same-cycle write-one-to-clear
            valid <= cap | (valid & ~(ctrl_wr & ctrl_wdata[CTRL_VALID]));
            ovf   <= sat | (ovf & ~(ctrl_wr & ctrl_wdata[CTRL_OVF]));

            if (arm) begin
                cnt <= CNT_W'(1);
            end else if (cap) begin
                period <= cnt;
                high   <= hi_tmp;
                cnt    <= CNT_W'(1);
            end else if (state == CAP_MEASURE && en) begin
                if (fall) hi_tmp <= cnt;
                if (!sat) cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign ctrl    = {ie, ovf, valid, en};
    assign irq_req = valid & ie;

endmodule

// File: rtl/pwm_capture.sv
// Eight-channel PWM input-capture peripheral on the rd/wr/adrs/din/dout bus.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   rd, wr   - read/write strobes sampled each clk
//   din      - write data
//   adrs     - byte address, channel n at CH_STRIDE*n (+0 CTRL, +4 PERIOD, +8 HIGH)
//   dout     - registered read data, 0 when not reading
//   pwmi     - asynchronous PWM inputs, one per channel
//   irq      - registered OR over channels of VALID & IE
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH    = pwm_pkg::NUM_CH,
    parameter int unsigned CNT_W     = pwm_pkg::CNT_W,
    parameter int unsigned CH_STRIDE = pwm_pkg::CH_STRIDE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       din,
    input  logic [6:0]        adrs,
    output logic [31:0]       dout,
    input  logic [NUM_CH-1:0] pwmi,
    output logic              irq
);

    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] irq_req;
    logic [3:0]        ctrl_q   [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  high_q   [NUM_CH];
    logic [31:0]       rdata;
    logic              din_unused;

    // only the low CTRL bits are writable
    assign din_unused = ^din[31:4];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ctrl_wr[g] = wr && (adrs == ch_base(g, CH_STRIDE) + OFS_CTRL);

        pwm_capture_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pwmi       (pwmi[g]),
            .ctrl_wr    (ctrl_wr[g]),
            .ctrl_wdata (din[3:0]),
            .ctrl       (ctrl_q[g]),
            .period     (period_q[g]),
            .high       (high_q[g]),
            .irq_req    (irq_req[g])
        );
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (adrs == ch_base(i, CH_STRIDE) + OFS_CTRL)   rdata = 32'(ctrl_q[i]);
            if (adrs == ch_base(i, CH_STRIDE) + OFS_PERIOD) rdata = 32'(period_q[i]);
            if (adrs == ch_base(i, CH_STRIDE) + OFS_HIGH)   rdata = 32'(high_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            irq  <= 1'b0;
        end else begin
            dout <= rd ? rdata : '0;
            irq  <= |irq_req;
        end
    end

endmodule
